// File: rtl/dot_product_pkg.sv
// Shared types and constants for the strided dot-product engine.
package dot_product_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_GAP,
        ST_DRAIN,
        ST_WR,
        ST_DONE
    } dp_state_e;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_ERR    = 2;
    localparam int STAT_OVF    = 3;
    localparam int MAC_LATENCY = 2;

endpackage

// File: rtl/dot_product_engine_mac.sv
// Two-stage multiply/accumulate: stage 1 registers the product, stage 2 accumulates.
// DOT_PRODUCT_SATURATE_EN: clamp and hold the accumulator on overflow instead of wrapping.
module dot_product_mac
    import dot_product_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc,
    output logic              overflow
);
    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0] a_s, b_s;
    logic        [PW-1:0] a_u, b_u, prod_d, prod_q;
    logic                 prod_vld;
    logic        [ACC_W-1:0] ext, sum, sat_val;
    logic        [ACC_W:0]   sum_w;
    logic                    ovf_now;

    always_comb begin
        a_s    = {{DATA_W{a[DATA_W-1]}}, a};
        b_s    = {{DATA_W{b[DATA_W-1]}}, b};
        a_u    = {{DATA_W{1'b0}}, a};
        b_u    = {{DATA_W{1'b0}}, b};
        prod_d = signed_mode ? PW'(a_s * b_s) : PW'(a_u * b_u);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            prod_q   <= '0;
            prod_vld <= 1'b0;
        end else begin
            prod_vld <= push;
            if (push) prod_q <= prod_d;
        end
    end

    // Signed overflow: operands agree in sign but the sum does not; unsigned: carry out.
    always_comb begin
        ext     = signed_mode ? ACC_W'($signed(prod_q)) : ACC_W'(prod_q);
        sum_w   = {1'b0, acc} + {1'b0, ext};
        sum     = sum_w[ACC_W-1:0];
        ovf_now = signed_mode ? ((acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]))
                              : sum_w[ACC_W];
        if (!signed_mode)       sat_val = '1;
        else if (ext[ACC_W-1])  sat_val = {1'b1, {(ACC_W-1){1'b0}}};
        else                    sat_val = {1'b0, {(ACC_W-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc      <= '0;
            overflow <= 1'b0;
        end else if (prod_vld) begin
`ifdef DOT_PRODUCT_SATURATE_EN
            if (!overflow) begin
                if (ovf_now) begin
                    acc      <= sat_val;
                    overflow <= 1'b1;
                end else begin
                    acc <= sum;
                end
            end
`else
            acc <= sum;
            if (ovf_now) overflow <= 1'b1;
`endif
        end
    end

endmodule

// File: rtl/dot_product_engine.sv
// Strided dot-product engine: fetches A/B element pairs, accumulates, writes the low word.
// Optional DOT_PRODUCT_SATURATE_EN (in dot_product_mac) selects saturating accumulation.
//
// state    | meaning
// IDLE     | waiting for a start edge
// RD_A     | read request for the next A element outstanding
// RD_B     | read request for the matching B element outstanding
// GAP      | single mode: one idle request cycle between elements
// DRAIN    | waiting for the MAC pipeline to empty
// WR       | write request outstanding
// DONE     | one-cycle completion state
module dot_product_engine
    import dot_product_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_in,
    input  logic              abort_in,
    input  logic              burst_mode,
    input  logic              signed_mode,
    input  logic [ADDR_W-1:0] addr_a_in,
    input  logic [ADDR_W-1:0] addr_b_in,
    input  logic [ADDR_W-1:0] addr_out_in,
    input  logic [ADDR_W-1:0] stride_a_in,
    input  logic [ADDR_W-1:0] stride_b_in,
    input  logic [LEN_W-1:0]  length_in,
    output logic [7:0]        status_out,
    output logic [ACC_W-1:0]  result_out,
    output logic              read_req,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [31:0]       read_data,
    input  logic              read_data_valid,
    output logic              write_req,
    output logic [ADDR_W-1:0] write_addr,
    output logic [31:0]       write_data,
    input  logic              write_done
);
    dp_state_e         state_q, state_d;
    logic              start_q, burst_q, burst_d, sgn_q, sgn_d;
    logic [ADDR_W-1:0] addr_out_q, addr_out_d, stride_a_q, stride_a_d, stride_b_q, stride_b_d;
    logic [ADDR_W-1:0] a_ptr_q, a_ptr_d, b_ptr_q, b_ptr_d, read_addr_d, write_addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [1:0]        drain_q, drain_d;
    logic [DATA_W-1:0] a_lat_q, a_lat_d;
    logic [31:0]       write_data_d;
    logic [ACC_W-1:0]  result_d, mac_acc;
    logic              read_req_d, write_req_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic              mac_clear, mac_push, mac_ovf, start_edge;

    assign start_edge = start_in && !start_q;
    assign status_out = {4'b0, mac_ovf, err_q, done_q, busy_q};

    always_comb begin
        state_d      = state_q;
        burst_d      = burst_q;
        sgn_d        = sgn_q;
        addr_out_d   = addr_out_q;
        stride_a_d   = stride_a_q;
        stride_b_d   = stride_b_q;
        a_ptr_d      = a_ptr_q;
        b_ptr_d      = b_ptr_q;
        remaining_d  = remaining_q;
        drain_d      = drain_q;
        a_lat_d      = a_lat_q;
        read_req_d   = read_req;
        read_addr_d  = read_addr;
        write_req_d  = write_req;
        write_addr_d = write_addr;
        write_data_d = write_data;
        result_d     = result_out;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        mac_clear    = 1'b0;
        mac_push     = 1'b0;

        unique case (state_q)
            ST_IDLE: if (start_edge) begin
                burst_d    = burst_mode;
                sgn_d      = signed_mode;
                addr_out_d = addr_out_in;
                stride_a_d = stride_a_in;
                stride_b_d = stride_b_in;
                mac_clear  = 1'b1;
                busy_d     = 1'b1;
                done_d     = 1'b0;
                if (length_in != '0) begin
                    a_ptr_d     = addr_a_in;
                    b_ptr_d     = addr_b_in;
                    remaining_d = length_in;
                    read_req_d  = 1'b1;
                    read_addr_d = addr_a_in;
                    err_d       = 1'b0;
                    state_d     = ST_RD_A;
                end else begin
                    err_d        = 1'b1;
                    write_req_d  = 1'b1;
                    write_addr_d = addr_out_in;
                    write_data_d = '0;
                    state_d      = ST_WR;
                end
            end
            ST_RD_A: if (read_data_valid) begin
                a_lat_d     = read_data[DATA_W-1:0];
                read_addr_d = b_ptr_q;
                state_d     = ST_RD_B;
            end
            ST_RD_B: if (read_data_valid) begin
                mac_push    = 1'b1;
                a_ptr_d     = a_ptr_q + stride_a_q;
                b_ptr_d     = b_ptr_q + stride_b_q;
                remaining_d = remaining_q - LEN_W'(1);
                if (remaining_q == LEN_W'(1)) begin
                    read_req_d = 1'b0;
                    drain_d    = 2'(MAC_LATENCY);
                    state_d    = ST_DRAIN;
                end else if (burst_q) begin
                    read_addr_d = a_ptr_q + stride_a_q;
                    state_d     = ST_RD_A;
                end else begin
                    read_req_d = 1'b0;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                read_req_d  = 1'b1;
                read_addr_d = a_ptr_q;
                state_d     = ST_RD_A;
            end
            ST_DRAIN: if (drain_q == 2'd1) begin
                write_req_d  = 1'b1;
                write_addr_d = addr_out_q;
                write_data_d = mac_acc[31:0];
                state_d      = ST_WR;
            end else begin
                drain_d = drain_q - 2'd1;
            end
            ST_WR: if (write_done) begin
                write_req_d = 1'b0;
                result_d    = mac_acc;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over any handshake completing in the same cycle.
        if (state_q != ST_IDLE && abort_in) begin
            state_d     = ST_IDLE;
            read_req_d  = 1'b0;
            write_req_d = 1'b0;
            busy_d      = 1'b0;
            err_d       = 1'b1;
            done_d      = 1'b0;
            mac_push    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            burst_q     <= 1'b0;
            sgn_q       <= 1'b0;
            addr_out_q  <= '0;
            stride_a_q  <= '0;
            stride_b_q  <= '0;
            a_ptr_q     <= '0;
            b_ptr_q     <= '0;
            remaining_q <= '0;
            drain_q     <= '0;
            a_lat_q     <= '0;
            read_req    <= 1'b0;
            read_addr   <= '0;
            write_req   <= 1'b0;
            write_addr  <= '0;
            write_data  <= '0;
            result_out  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_in;
            burst_q     <= burst_d;
            sgn_q       <= sgn_d;
            addr_out_q  <= addr_out_d;
            stride_a_q  <= stride_a_d;
            stride_b_q  <= stride_b_d;
            a_ptr_q     <= a_ptr_d;
            b_ptr_q     <= b_ptr_d;
            remaining_q <= remaining_d;
            drain_q     <= drain_d;
            a_lat_q     <= a_lat_d;
            read_req    <= read_req_d;
            read_addr   <= read_addr_d;
            write_req   <= write_req_d;
            write_addr  <= write_addr_d;
            write_data  <= write_data_d;
            result_out  <= result_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    dot_product_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk         (clk),
        .reset       (reset),
        .clear       (mac_clear),
        .push        (mac_push),
        .signed_mode (sgn_q),
        .a           (a_lat_q),
        .b           (read_data[DATA_W-1:0]),
        .acc         (mac_acc),
        .overflow    (mac_ovf)
    );

endmodule

// File: tb/tb_dot_product_engine.sv
// Self-checking bench for dot_product_engine: memory/write responders plus an arithmetic reference model.
module tb_dot_product_engine;
    import dot_product_pkg::*;

    logic        clk, reset, start_in, abort_in, burst_mode, signed_mode;
    logic [31:0] addr_a_in, addr_b_in, addr_out_in, stride_a_in, stride_b_in;
    logic [15:0] length_in;
    logic [7:0]  status_out;
    logic [63:0] result_out;
    logic        read_req, read_data_valid, write_req, write_done;
    logic [31:0] read_addr, read_data, write_addr, write_data;

    dot_product_engine dut (
        .clk(clk), .reset(reset), .start_in(start_in), .abort_in(abort_in),
        .burst_mode(burst_mode), .signed_mode(signed_mode),
        .addr_a_in(addr_a_in), .addr_b_in(addr_b_in), .addr_out_in(addr_out_in),
        .stride_a_in(stride_a_in), .stride_b_in(stride_b_in), .length_in(length_in),
        .status_out(status_out), .result_out(result_out),
        .read_req(read_req), .read_addr(read_addr), .read_data(read_data),
        .read_data_valid(read_data_valid), .write_req(write_req), .write_addr(write_addr),
        .write_data(write_data), .write_done(write_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] qa[$], qb[$], rd_log[$], wr_addr_log[$], wr_data_log[$];
    int rd_lat = 2, wr_lat = 1, rd_cnt = 0, wr_cnt = 0, reads_done = 0, low_cnt = 0, cur_len = 0;

    // Memory and write-port responders; also count idle read_req cycles inside a job.
    initial begin
        read_data_valid = 1'b0; read_data = '0; write_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (read_data_valid) begin
                read_data_valid = 1'b0; rd_cnt = 0; reads_done++;
            end
            if (reset || !read_req) rd_cnt = 0;
            else if (rd_cnt >= rd_lat) begin
                read_data_valid = 1'b1;
                read_data = mem.exists(read_addr) ? mem[read_addr] : 32'hDEAD_BEEF;
                rd_log.push_back(read_addr);
            end else rd_cnt++;
            if (!read_req && reads_done > 0 && reads_done < 2 * cur_len) low_cnt++;
            if (write_done) begin
                write_done = 1'b0; wr_cnt = 0;
            end else if (write_req && !reset) begin
                if (wr_cnt >= wr_lat) begin
                    write_done = 1'b1;
                    wr_addr_log.push_back(write_addr);
                    wr_data_log.push_back(write_data);
                end else wr_cnt++;
            end else wr_cnt = 0;
        end
    end

    task automatic launch(input logic [31:0] ab, bb, sa, sb, ob, input int len, input bit burst, sgn);
        mem.delete();
        for (int i = 0; i < len; i++) begin
            mem[ab + 32'(i) * sa] = qa[i];
            mem[bb + 32'(i) * sb] = qb[i];
        end
        rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
        reads_done = 0; low_cnt = 0; cur_len = len;
        @(negedge clk);
        addr_a_in = ab; addr_b_in = bb; stride_a_in = sa; stride_b_in = sb; addr_out_in = ob;
        length_in = 16'(len); burst_mode = burst; signed_mode = sgn; start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (status_out[STAT_DONE] !== 1'b1 && cyc < 3000) begin
            @(negedge clk); cyc++;
        end
        if (cyc >= 3000) begin
            checks++; errors++;
            $display("FAIL job_timeout: done=%b after %0d cycles, required 1", status_out[STAT_DONE], cyc);
        end
        repeat (3) @(negedge clk);
    endtask

    // Reference: exact integer sum of products, range-checked against the 64-bit accumulator.
    task automatic model(input int len, input bit sgn, output logic [63:0] acc, output bit ovf);
        logic signed [129:0] x, y, cur, exact, hi, lo, one;
        logic [31:0] ai, bi;
        one = 1; acc = '0; ovf = 1'b0;
        hi = sgn ? (one <<< 63) - one : (one <<< 64) - one;
        lo = sgn ? -(one <<< 63) : 130'sd0;
        for (int i = 0; i < len; i++) begin
            ai = qa[i]; bi = qb[i];
            x = sgn ? {{98{ai[31]}}, ai} : {98'b0, ai};
            y = sgn ? {{98{bi[31]}}, bi} : {98'b0, bi};
            cur = sgn ? {{66{acc[63]}}, acc} : {66'b0, acc};
            exact = cur + x * y;
`ifdef DOT_PRODUCT_SATURATE_EN
            if (!ovf) begin
                if (exact > hi) begin acc = hi[63:0]; ovf = 1'b1; end
                else if (exact < lo) begin acc = lo[63:0]; ovf = 1'b1; end
                else acc = exact[63:0];
            end
`else
            if (exact > hi || exact < lo) ovf = 1'b1;
            acc = exact[63:0];
`endif
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (status_out !== 8'h00) begin errors++; $display("FAIL reset_status: got %h, required 00", status_out); end
        checks++; if (read_req !== 1'b0 || write_req !== 1'b0) begin errors++; $display("FAIL reset_req: got rd=%b wr=%b, required 0 0", read_req, write_req); end
        checks++; if (result_out !== 64'd0 || write_data !== 32'd0 || read_addr !== 32'd0 || write_addr !== 32'd0)
            begin errors++; $display("FAIL reset_data: result=%h wdata=%h raddr=%h waddr=%h, required all 0", result_out, write_data, read_addr, write_addr); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int bad = 0;
        qa = '{1, 2, 3, 4}; qb = '{5, 6, 7, 8}; rd_lat = 2; wr_lat = 1;
        launch(32'h100, 32'h200, 8, 8, 32'h300, 4, 0, 0);
        wait_done();
        for (int i = 0; i < 4; i++) begin
            if (rd_log[2*i] !== 32'h100 + 32'(8*i)) bad++;
            if (rd_log[2*i+1] !== 32'h200 + 32'(8*i)) bad++;
        end
        checks++; if (rd_log.size() != 8 || bad != 0) begin errors++; $display("FAIL single_read_seq: %0d reads, %0d wrong addresses, required 8 and 0", rd_log.size(), bad); end
        checks++; if (low_cnt != 3) begin errors++; $display("FAIL single_gap: got %0d idle req cycles, required 3", low_cnt); end
        checks++; if (wr_data_log.size() != 1 || wr_data_log[0] !== 32'd70 || wr_addr_log[0] !== 32'h300)
            begin errors++; $display("FAIL single_write: %0d writes data=%h addr=%h, required 1 write 46 at 300", wr_data_log.size(), wr_data_log[0], wr_addr_log[0]); end
        checks++; if (status_out !== 8'h02) begin errors++; $display("FAIL single_status: got %h, required 02", status_out); end
        checks++; if (result_out !== 64'd70) begin errors++; $display("FAIL single_result: got %h, required 46", result_out); end
    endtask

    task automatic test_burst();
        qa = '{1, 2, 3, 4}; qb = '{5, 6, 7, 8}; rd_lat = 0; wr_lat = 0;
        launch(32'h100, 32'h200, 8, 8, 32'h300, 4, 1, 0);
        wait_done();
        checks++; if (low_cnt != 0) begin errors++; $display("FAIL burst_gap: got %0d idle req cycles, required 0", low_cnt); end
        checks++; if (rd_log.size() != 8) begin errors++; $display("FAIL burst_reads: got %0d, required 8", rd_log.size()); end
        checks++; if (result_out !== 64'd70 || write_data !== 32'd70) begin errors++; $display("FAIL burst_result: got %h/%h, required 46", result_out, write_data); end
    endtask

    task automatic test_signed_unsigned();
        qa = '{32'hFFFF_FFFD, 32'h7FFF_FFFF}; qb = '{4, 2}; rd_lat = 1; wr_lat = 2;
        launch(32'h400, 32'h500, 4, 4, 32'h600, 2, 0, 1);
        wait_done();
        checks++; if (result_out !== 64'h0000_0000_FFFF_FFF2) begin errors++; $display("FAIL signed_result: got %h, required 00000000fffffff2", result_out); end
        checks++; if (status_out !== 8'h02) begin errors++; $display("FAIL signed_status: got %h, required 02", status_out); end
        qa = '{32'hFFFF_FFFF}; qb = '{32'hFFFF_FFFF};
        launch(32'h400, 32'h500, 4, 4, 32'h600, 1, 1, 0);
        wait_done();
        checks++; if (result_out !== 64'hFFFF_FFFE_0000_0001 || write_data !== 32'h1)
            begin errors++; $display("FAIL unsigned_result: got %h/%h, required fffffffe00000001/00000001", result_out, write_data); end
    endtask

    task automatic test_zero_len();
        launch(32'h100, 32'h200, 8, 8, 32'h700, 0, 0, 0);
        wait_done();
        checks++; if (rd_log.size() != 0) begin errors++; $display("FAIL zero_reads: got %0d, required 0", rd_log.size()); end
        checks++; if (wr_data_log.size() != 1 || wr_data_log[0] !== 32'd0 || wr_addr_log[0] !== 32'h700)
            begin errors++; $display("FAIL zero_write: %0d writes data=%h addr=%h, required 1 write 0 at 700", wr_data_log.size(), wr_data_log[0], wr_addr_log[0]); end
        checks++; if (status_out !== 8'h06) begin errors++; $display("FAIL zero_status: got %h, required 06", status_out); end
    endtask

    task automatic test_abort();
        int n = 0;
        qa = '{1, 2, 3, 4}; qb = '{5, 6, 7, 8}; rd_lat = 1; wr_lat = 1;
        launch(32'h100, 32'h200, 8, 8, 32'h300, 4, 0, 0);
        while (reads_done < 1 && n < 200) begin @(negedge clk); n++; end
        rd_lat = 1000;
        abort_in = 1'b1;
        @(negedge clk);
        abort_in = 1'b0;
        checks++; if (read_req !== 1'b0) begin errors++; $display("FAIL abort_req: got %b, required 0", read_req); end
        checks++; if (status_out !== 8'h04) begin errors++; $display("FAIL abort_status: got %h, required 04", status_out); end
        repeat (10) @(negedge clk);
        checks++; if (wr_data_log.size() != 0 || status_out !== 8'h04) begin errors++; $display("FAIL abort_nowrite: %0d writes status=%h, required 0 and 04", wr_data_log.size(), status_out); end
        rd_lat = 2;
        launch(32'h100, 32'h200, 8, 8, 32'h300, 4, 0, 0);
        wait_done();
        checks++; if (result_out !== 64'd70 || status_out !== 8'h02) begin errors++; $display("FAIL abort_rerun: got %h status %h, required 46 and 02", result_out, status_out); end
        // reset in the middle of a job discards it
        rd_lat = 1000;
        launch(32'h100, 32'h200, 8, 8, 32'h300, 4, 1, 0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (read_req !== 1'b0 || status_out !== 8'h00 || wr_data_log.size() != 0)
            begin errors++; $display("FAIL reset_midjob: req=%b status=%h writes=%0d, required 0 00 0", read_req, status_out, wr_data_log.size()); end
        rd_lat = 2;
    endtask

    task automatic test_overflow();
        logic [63:0] exp_acc; bit exp_ovf;
        qa = '{32'h8000_0000, 32'h8000_0000}; qb = '{32'h8000_0000, 32'h8000_0000};
        model(2, 1, exp_acc, exp_ovf);
        launch(32'h100, 32'h200, 4, 4, 32'h300, 2, 1, 1);
        wait_done();
        checks++; if (status_out !== 8'h0A) begin errors++; $display("FAIL ovf_signed_status: got %h, required 0a", status_out); end
        checks++; if (result_out !== exp_acc || write_data !== exp_acc[31:0]) begin errors++; $display("FAIL ovf_signed_result: got %h/%h, required %h", result_out, write_data, exp_acc); end
        qa = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h3}; qb = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5};
        model(3, 0, exp_acc, exp_ovf);
        launch(32'h100, 32'h200, 4, 4, 32'h300, 3, 0, 0);
        wait_done();
        checks++; if (status_out[STAT_OVF] !== 1'b1 || result_out !== exp_acc) begin errors++; $display("FAIL ovf_unsigned: ovf=%b result=%h, required 1 and %h", status_out[STAT_OVF], result_out, exp_acc); end
    endtask

    task automatic test_random();
        logic [63:0] exp_acc; bit exp_ovf;
        logic [31:0] ab, bb, sa, sb;
        int len, bad;
        bit burst, sgn;
        for (int it = 0; it < 10; it++) begin
            len = $urandom_range(1, 6); burst = 1'($urandom); sgn = 1'($urandom);
            rd_lat = $urandom_range(0, 3); wr_lat = $urandom_range(0, 3);
            ab = (it == 0) ? 32'hFFFF_FFF8 : 32'h1000 + 32'($urandom_range(0, 255)) * 4;
            bb = 32'h8000 + 32'($urandom_range(0, 255)) * 4;
            sa = 32'($urandom_range(1, 16)) * 4; sb = 32'($urandom_range(1, 16)) * 4;
            qa.delete(); qb.delete();
            for (int i = 0; i < len; i++) begin
                qa.push_back((it % 3 == 2) ? 32'h8000_0000 | $urandom : $urandom);
                qb.push_back((it % 3 == 2) ? 32'h8000_0000 | $urandom : $urandom);
            end
            model(len, sgn, exp_acc, exp_ovf);
            launch(ab, bb, sa, sb, 32'hA000, len, burst, sgn);
            wait_done();
            bad = 0;
            for (int i = 0; i < len; i++) begin
                if (rd_log[2*i] !== ab + 32'(i) * sa) bad++;
                if (rd_log[2*i+1] !== bb + 32'(i) * sb) bad++;
            end
            checks++; if (rd_log.size() != 2 * len || bad != 0) begin errors++; $display("FAIL rand%0d_reads: %0d reads %0d wrong, required %0d and 0", it, rd_log.size(), bad, 2 * len); end
            checks++; if (result_out !== exp_acc || write_data !== exp_acc[31:0]) begin errors++; $display("FAIL rand%0d_result: got %h/%h, required %h", it, result_out, write_data, exp_acc); end
            checks++; if (status_out !== {4'b0, exp_ovf, 3'b010}) begin errors++; $display("FAIL rand%0d_status: got %h, required %h", it, status_out, {4'b0, exp_ovf, 3'b010}); end
            checks++; if (low_cnt != (burst ? 0 : len - 1)) begin errors++; $display("FAIL rand%0d_gap: got %0d, required %0d", it, low_cnt, burst ? 0 : len - 1); end
        end
    endtask

    initial begin
        reset = 1'b1; start_in = 1'b0; abort_in = 1'b0; burst_mode = 1'b0; signed_mode = 1'b0;
        addr_a_in = '0; addr_b_in = '0; addr_out_in = '0; stride_a_in = '0; stride_b_in = '0; length_in = '0;
        test_reset();
        test_single();
        test_burst();
        test_signed_unsigned();
        test_zero_len();
        test_abort();
        test_overflow();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
